// File: rtl/insdecode_defs.sv
`default_nettype none
// ============================================================================
//  Module   : insdecode_defs (package)
//  Purpose  : Shared opcode/funct encodings, ALU op codes, control-bit
//             indices and the combinational instruction decoder used by
//             insdecode_stage.
//  Revision : 1.0  initial release
// ============================================================================
package insdecode_defs;

  localparam int REG_AW = 5;

  // Primary opcodes (inscode[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (inscode[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_NOP = 3'd7;

  // Bit positions inside ctrl = {reg_write, alu_src, mem_read, mem_write, branch, jump}
  localparam int CTRL_REG_WRITE = 5;
  localparam int CTRL_ALU_SRC   = 4;
  localparam int CTRL_MEM_READ  = 3;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_BRANCH    = 1;
  localparam int CTRL_JUMP      = 0;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic [2:0]        alu_op;
    logic [5:0]        ctrl;
    logic              illegal;
  } dec_t;

  // Pure decode of one instruction word; anything unrecognised becomes an
  // illegal bundle with no side effects (ctrl=0, NOP, no destination).
  function automatic dec_t decode_ins(input logic [31:0] ins);
    dec_t d;
    d.dest    = '0;
    d.alu_op  = ALU_NOP;
    d.ctrl    = '0;
    d.illegal = 1'b0;
    // The all-zero word (sll r0,r0,0) is the canonical nop: legal, inert.
    if (ins != 32'h0000_0000) begin
      case (ins[31:26])
        OP_RTYPE: begin
          d.ctrl[CTRL_REG_WRITE] = 1'b1;
          d.dest                 = ins[15:11];
          case (ins[5:0])
            FN_ADD:  d.alu_op = ALU_ADD;
            FN_SUB:  d.alu_op = ALU_SUB;
            FN_AND:  d.alu_op = ALU_AND;
            FN_OR:   d.alu_op = ALU_OR;
            FN_SLT:  d.alu_op = ALU_SLT;
            default: begin
              d.ctrl    = '0;
              d.dest    = '0;
              d.alu_op  = ALU_NOP;
              d.illegal = 1'b1;
            end
          endcase
        end
        OP_ADDI: begin
          d.ctrl[CTRL_REG_WRITE] = 1'b1;
          d.ctrl[CTRL_ALU_SRC]   = 1'b1;
          d.alu_op               = ALU_ADD;
          d.dest                 = ins[20:16];
        end
        OP_LW: begin
          d.ctrl[CTRL_REG_WRITE] = 1'b1;
          d.ctrl[CTRL_ALU_SRC]   = 1'b1;
          d.ctrl[CTRL_MEM_READ]  = 1'b1;
          d.alu_op               = ALU_ADD;
          d.dest                 = ins[20:16];
        end
        OP_SW: begin
          d.ctrl[CTRL_ALU_SRC]   = 1'b1;
          d.ctrl[CTRL_MEM_WRITE] = 1'b1;
          d.alu_op               = ALU_ADD;
        end
        OP_BEQ: begin
          d.ctrl[CTRL_BRANCH] = 1'b1;
          d.alu_op            = ALU_SUB;
        end
        OP_J: begin
          d.ctrl[CTRL_JUMP] = 1'b1;
        end
        default: d.illegal = 1'b1;
      endcase
    end
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : decode_regfile
//  Purpose  : NREGS x XLEN register file, two asynchronous read ports and one
//             synchronous write port. Register 0 reads as zero and ignores
//             writes. Whole array clears on asynchronous reset.
//  Config   : WB_BYPASS_EN - when defined, a same-cycle write to a register
//             being read is forwarded to the read port.
//  Revision : 1.0  initial release
// ============================================================================
module decode_regfile
  import insdecode_defs::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [XLEN-1:0]   rs_data,
  output logic [XLEN-1:0]   rt_data
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr;

  assign w_wr = wb_en && (wb_addr != '0);

  // Storage: async clear, synchronous write; register 0 is never written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Read ports: register 0 is hardwired to zero, optional write-through.
  always_comb begin
    rs_data = (rs_addr == '0) ? '0 : r_regs[rs_addr];
    rt_data = (rt_addr == '0) ? '0 : r_regs[rt_addr];
`ifdef WB_BYPASS_EN
    if (w_wr && (wb_addr == rs_addr)) rs_data = wb_data;
    if (w_wr && (wb_addr == rt_addr)) rt_data = wb_data;
`endif
  end

endmodule
`default_nettype wire

// File: rtl/insdecode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : insdecode_stage
//  Purpose  : Decode stage after fetch. Splits inscode into fields, reads two
//             operands from the register file, generates control, and holds
//             the result in one output register with valid/ready toward
//             execute. Owns the writeback port of the register file.
//  Config   : WB_BYPASS_EN - forward same-cycle writeback data to operands.
//  Revision : 1.0  initial release
// ============================================================================
module insdecode_stage
  import insdecode_defs::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inscode,
  input  logic [XLEN-1:0]   pc_in,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   rs_data,
  output logic [XLEN-1:0]   rt_data,
  output logic [XLEN-1:0]   imm_ext,
  output logic [REG_AW-1:0] dest_reg,
  output logic [2:0]        alu_op,
  output logic [5:0]        ctrl,
  output logic [25:0]       jump_tgt,
  output logic              illegal
);

  logic              r_valid;
  logic [XLEN-1:0]   r_pc, r_rs, r_rt, r_imm;
  logic [REG_AW-1:0] r_dest;
  logic [2:0]        r_alu_op;
  logic [5:0]        r_ctrl;
  logic [25:0]       r_jump_tgt;
  logic              r_illegal;

  logic [XLEN-1:0]   w_rs, w_rt, w_imm;
  logic              w_xfer;
  dec_t              w_dec;

  decode_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rs_addr (inscode[25:21]),
    .rt_addr (inscode[20:16]),
    .rs_data (w_rs),
    .rt_data (w_rt)
  );

  // The output register may take a new bundle whenever it is empty or drains.
  assign in_ready = !r_valid || out_ready;
  assign w_xfer   = in_valid && in_ready;
  assign w_dec    = decode_ins(inscode);
  assign w_imm    = {{(XLEN-16){inscode[15]}}, inscode[15:0]};

  // Output pipeline register: load on transfer, empty when drained, hold on stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid    <= 1'b0;
      r_pc       <= RESET_PC;
      r_rs       <= '0;
      r_rt       <= '0;
      r_imm      <= '0;
      r_dest     <= '0;
      r_alu_op   <= ALU_NOP;
      r_ctrl     <= '0;
      r_jump_tgt <= '0;
      r_illegal  <= 1'b0;
    end else if (w_xfer) begin
      r_valid    <= 1'b1;
      r_pc       <= pc_in;
      r_rs       <= w_rs;
      r_rt       <= w_rt;
      r_imm      <= w_imm;
      r_dest     <= w_dec.dest;
      r_alu_op   <= w_dec.alu_op;
      r_ctrl     <= w_dec.ctrl;
      r_jump_tgt <= inscode[25:0];
      r_illegal  <= w_dec.illegal;
    end else if (out_ready) begin
      r_valid    <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign pc_out    = r_pc;
  assign rs_data   = r_rs;
  assign rt_data   = r_rt;
  assign imm_ext   = r_imm;
  assign dest_reg  = r_dest;
  assign alu_op    = r_alu_op;
  assign ctrl      = r_ctrl;
  assign jump_tgt  = r_jump_tgt;
  assign illegal   = r_illegal;

endmodule
`default_nettype wire
